// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - Serial pattern detector control/status bundle
//
// Signals (master = stimulus/host side, slave = detector):
//   din        serial data bit, sampled when en=1
//   en         bit-valid qualifier
//   clr        synchronous clear of history, fill count and match count
//   pattern    target sequence, pattern[len-1] is the first bit received
//   len        active pattern length (1..MAX_LEN)
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   mode       0 = Mealy (combinational) out, 1 = registered out
//   out        match indication
//   match_cnt  saturating count of detected matches
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 5
);
    logic               din;
    logic               en;
    logic               clr;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic               mode;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output din, en, clr, pattern, len, overlap, mode,
        input  out, match_cnt
    );

    modport slave (
        input  din, en, clr, pattern, len, overlap, mode,
        output out, match_cnt
    );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - Parameterised serial sequence detector with match counter
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_detector_param_if.slave (din/en/clr/pattern/len/overlap/mode in,
//          out/match_cnt out)
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    seq_detector_param_if.slave bus
);
    localparam int               FW      = $clog2(MAX_LEN + 1);
    localparam logic [FW-1:0]    F_MAX   = FW'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The newest bit of any window always comes from din, so only the last
    // MAX_LEN-1 received bits can ever take part in a comparison.
    logic [MAX_LEN-2:0] hist;
    logic [FW-1:0]      fill;
    logic [CNT_W-1:0]   cnt;
    logic               out_q;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               len_ok;
    logic               fill_ok;
    logic               match;

    assign window = {hist, bus.din};

    // Only the low len bits of the window/pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(bus.len));
        end
    end

    assign len_ok  = (bus.len != '0) && (int'(bus.len) <= MAX_LEN);
    assign fill_ok = (int'(fill) + 1) >= int'(bus.len);
    assign match   = bus.en & len_ok & fill_ok &
                     (((window ^ bus.pattern) & mask) == '0);

    // Mealy output is gated by reset so it reads 0 while reset is held.
    assign bus.out       = bus.mode ? out_q : (rst_n & match);
    assign bus.match_cnt = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            fill  <= '0;
            cnt   <= '0;
            out_q <= 1'b0;
        end else if (bus.clr) begin
            fill  <= '0;
            cnt   <= '0;
            out_q <= 1'b0;
        end else begin
            out_q <= match;
            if (bus.en) begin
                hist <= window[MAX_LEN-2:0];
                // Non-overlapping: emptying the fill count makes the old
                // history unusable, so it need not be cleared.
                if (match && !bus.overlap) begin
                    fill <= '0;
                end else if (fill != F_MAX) begin
                    fill <= fill + 1'b1;
                end
                if (match && cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - Self-checking bench for seq_detector_param
module tb_seq_detector_param;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       din, en, clr, ovl, mode;
    logic [7:0] pat;
    logic [4:0] len;

    always #5 clk = ~clk;

    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8), .LEN_W(5)) bus1 ();
    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2), .LEN_W(5)) bus2 ();

    assign bus1.din = din;     assign bus2.din = din;
    assign bus1.en = en;       assign bus2.en = en;
    assign bus1.clr = clr;     assign bus2.clr = clr;
    assign bus1.pattern = pat; assign bus2.pattern = pat;
    assign bus1.len = len;     assign bus2.len = len;
    assign bus1.overlap = ovl; assign bus2.overlap = ovl;
    assign bus1.mode = mode;   assign bus2.mode = mode;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8), .LEN_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    seq_detector_param #(.MAX_LEN(8), .CNT_W(2), .LEN_W(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    typedef struct {
        string      tag;
        logic [7:0] pat;
        logic [4:0] len;
        bit         mode;
        bit         ovl;
        bit         clr;
        bit         en;
        bit         din;
        bit         exp_out;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        string tag;
        int    idx;
        bit    mode;
        bit    exp_out;
        int    exp_cnt;
    } exp_t;

    vec_t       tbl[$];
    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;

    string      cur_tag;
    logic [7:0] cur_pat;
    logic [4:0] cur_len;
    bit         cur_mode, cur_ovl;

    function automatic vec_t mkv(bit c, bit e, bit d, bit eo, int ec);
        vec_t v;
        v.tag = cur_tag; v.pat = cur_pat; v.len = cur_len;
        v.mode = cur_mode; v.ovl = cur_ovl;
        v.clr = c; v.en = e; v.din = d; v.exp_out = eo; v.exp_cnt = ec;
        return v;
    endfunction

    function automatic void add(bit c, bit e, bit d, bit eo, int ec);
        tbl.push_back(mkv(c, e, d, eo, ec));
    endfunction

    function automatic void section(string t, logic [7:0] p, logic [4:0] l, bit m, bit o);
        cur_tag = t; cur_pat = p; cur_len = l; cur_mode = m; cur_ovl = o;
    endfunction

    function automatic void chk(string name, int idx, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
        end
    endfunction

    // One bit slot: drive at negedge, sample Mealy out before the edge,
    // registered out and counts after it.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        bit   pre;
        int   sat;
        @(negedge clk);
        pat = v.pat; len = v.len; mode = v.mode; ovl = v.ovl;
        clr = v.clr; en = v.en; din = v.din;
        sb.push_back('{v.tag, idx, v.mode, v.exp_out, v.exp_cnt});
        #2 pre = bus1.out;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        sat = (e.exp_cnt > 3) ? 3 : e.exp_cnt;
        chk({e.tag, "_out"}, e.idx, int'(e.mode ? bus1.out : pre), int'(e.exp_out));
        chk({e.tag, "_cnt"}, e.idx, int'(bus1.match_cnt), e.exp_cnt);
        chk({e.tag, "_cnt2"}, e.idx, int'(bus2.match_cnt), sat);
    endtask

    initial begin
        bit a_bits[9] = '{0, 1, 1, 0, 1, 1, 1, 0, 1};
        bit a_out[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        int a_cnt[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
        bit b_bits[7] = '{1, 1, 0, 1, 1, 0, 1};
        bit b_out[7]  = '{0, 0, 0, 1, 0, 0, 1};
        int b_cnt[7]  = '{0, 0, 0, 1, 1, 1, 2};
        bit g_bits[11] = '{1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
        bit g_en[11]   = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};

        section("ovl_a", 8'h0D, 5'd4, 1'b0, 1'b1);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 1, a_bits[i], a_out[i], a_cnt[i]);

        section("moore", 8'h0D, 5'd4, 1'b1, 1'b1);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 1, a_bits[i], a_out[i], a_cnt[i]);
        add(0, 0, 1, 0, 2);

        section("ovl_b", 8'h0D, 5'd4, 1'b0, 1'b1);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 1, b_bits[i], b_out[i], b_cnt[i]);

        section("novl", 8'h0D, 5'd4, 1'b0, 1'b0);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 1, b_bits[i], (i == 3), (i >= 3) ? 1 : 0);

        section("gap", 8'hA5, 5'd8, 1'b0, 1'b1);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) add(0, g_en[i], g_bits[i], (i == 10), (i == 10) ? 1 : 0);

        section("len0", 8'h00, 5'd0, 1'b0, 1'b1);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0);

        section("len9", 8'hFF, 5'd9, 1'b0, 1'b1);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 1, 1, 0, 0);

        section("sat", 8'h01, 5'd1, 1'b0, 1'b1);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 1, i + 1);
        cur_mode = 1'b1;
        add(1, 1, 1, 0, 0);

        // Reset state, with a would-be match present on the inputs.
        rst_n = 1'b0; pat = 8'h01; len = 5'd1; mode = 1'b0; ovl = 1'b1;
        clr = 1'b0; en = 1'b1; din = 1'b1;
        #3;
        chk("reset_out", 0, int'(bus1.out), 0);
        chk("reset_cnt", 0, int'(bus1.match_cnt), 0);
        chk("reset_cnt2", 0, int'(bus2.match_cnt), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // Reset mid-sequence discards history: 1,1,0 then reset then 1.
        section("rst_mid", 8'h01, 5'd1, 1'b0, 1'b1);
        step(mkv(0, 1, 1, 1, 1), 0);
        section("rst_mid", 8'h0D, 5'd4, 1'b0, 1'b1);
        step(mkv(0, 1, 1, 0, 1), 1);
        step(mkv(0, 1, 1, 0, 1), 2);
        step(mkv(0, 1, 0, 0, 1), 3);
        @(negedge clk);
        din = 1'b1; en = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 4, int'(bus1.out), 0);
        chk("rst_mid_cnt", 4, int'(bus1.match_cnt), 0);
        chk("rst_mid_cnt2", 4, int'(bus2.match_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(mkv(0, 1, 1, 0, 0), 5);
        step(mkv(0, 1, 1, 0, 0), 6);

        chk("sb_empty", 0, sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (2..16).
REQ-002 Parameter CNT_W, default 8, width of the match counter.
REQ-003 Parameter LEN_W, default 5, width of the LEN port; SHALL be at least clog2(MAX_LEN+1).
REQ-004 CLK  input  1  system clock; all state changes on the rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 IN  input  1  serial data bit, sampled on the rising CLK edge when EN=1.
REQ-007 EN  input  1  bit-valid qualifier; IN is ignored when EN=0.
REQ-008 CLR  input  1  synchronous clear of history, fill count and MATCH_CNT.
REQ-009 PATTERN  input  MAX_LEN  target sequence; PATTERN[LEN-1] is the first bit received, PATTERN[0] the last.
REQ-010 LEN  input  LEN_W  active pattern length, valid range 1..MAX_LEN.
REQ-011 OVERLAP  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 MODE  input  1  0 = Mealy output, 1 = registered (Moore-timed) output.
REQ-013 OUT  output  1  match indication.
REQ-014 MATCH_CNT  output  CNT_W  saturating count of detected matches.

Function
REQ-015 History register H (MAX_LEN bits) SHALL hold received bits, with the newest bit in H[0].
REQ-016 Fill counter F (0..MAX_LEN) SHALL count valid history bits.
REQ-017 Match condition: EN=1, 1<=LEN<=MAX_LEN, F>=LEN-1, and the window {H[LEN-2:0], IN} equals PATTERN[LEN-1:0]; for LEN=1 the window is IN alone.
REQ-018 An EN=1 edge with no match and CLR=0: H shifts left with IN entering at H[0]; F increments, saturating at MAX_LEN.
REQ-019 An EN=1 edge with a match and OVERLAP=1: H shifts and F increments as in REQ-018, so the matched bits remain usable for the next match.
REQ-020 An EN=1 edge with a match and OVERLAP=0: F is set to 0; H contents are then irrelevant.
REQ-021 EN=0 edge: H, F and MATCH_CNT hold; gaps in EN SHALL NOT break a sequence.
REQ-022 MODE=0: OUT is combinational and equal to the match condition, i.e. high during the cycle in which the last pattern bit is present on IN.
REQ-023 MODE=1: OUT is a register loaded with the match condition at each edge; it is high for exactly one cycle after the matching edge, and is 0 after an EN=0 edge.
REQ-024 On each matching edge, MATCH_CNT SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 LEN=0 or LEN>MAX_LEN: no match ever occurs; OUT=0; F and H still update per REQ-018.
REQ-026 CLR=1 at an edge: F=0, MATCH_CNT=0, registered OUT=0, and IN is not shifted in; CLR has priority over EN.
REQ-027 Simultaneous CLR=1 and a match condition: no count increment; the Mealy OUT may pulse combinationally but the registered OUT stays 0.
REQ-028 PATTERN, LEN, OVERLAP and MODE are compared live; a change while EN=1 takes effect on the next edge and does not clear history; software issues CLR after a change.
REQ-029 Implementation: H shift register, F counter, comparator, output register and saturating counter; no other state.

Reset
REQ-030 RST=0 SHALL immediately force H=0, F=0, MATCH_CNT=0 and registered OUT=0, and Mealy OUT=0 while reset is held.
REQ-031 A reset asserted mid-sequence SHALL discard all partial history; detection restarts from an empty window once RST=1.

Verification
REQ-032 PATTERN=4'b1101, LEN=4, OVERLAP=1, MODE=0; IN=0,1,1,0,1,1,1,0,1 on consecutive EN edges -> OUT high with bits 5 and 9; MATCH_CNT=2.
REQ-033 Same setup with IN=1,1,0,1,1,0,1 -> OVERLAP=1 gives OUT at bits 4 and 7 and MATCH_CNT=2; OVERLAP=0 gives OUT at bit 4 only and MATCH_CNT=1.
REQ-034 Stimulus of REQ-032 with MODE=1 -> OUT high in the cycles after the bit 5 and bit 9 edges, one cycle wide each.
REQ-035 Send 1,1,0, pull RST low for one cycle, then send 1 -> no match; OUT=0; MATCH_CNT=0.
REQ-036 PATTERN=8'hA5, LEN=8; send 1,0,1,0,0,1,0,1 with EN=0 inserted for 3 cycles after bit 4 -> a single match at bit 8; MATCH_CNT=1.
REQ-037 CNT_W=2, LEN=1, PATTERN[0]=1; send five 1s -> MATCH_CNT sequence 1,2,3,3,3; then CLR=1 with IN=1 -> MATCH_CNT=0 and no increment.
